// File: rtl/ysyx_24090018_imem_resp.sv
// Instruction-memory responder: accepts one fetch at a time, returns the addressed
// word (or an error flag) after LATENCY wait cycles; RAM is preloaded via a backdoor port.
module ysyx_24090018_imem_resp #(
   parameter int unsigned        PC_ADDR    = 32,
   parameter int unsigned        DATA_WIDTH = 32,
   parameter int unsigned        DEPTH_LOG2 = 10,
   parameter int unsigned        LATENCY    = 2,
   parameter logic [PC_ADDR-1:0] BASE_ADDR  = 32'h8000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [PC_ADDR-1:0]    req_addr_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_inst_o,
   output logic                  rsp_err_o,
   input  logic                  ld_we_i,
   input  logic [DEPTH_LOG2-1:0] ld_addr_i,
   input  logic [DATA_WIDTH-1:0] ld_data_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   localparam logic [3:0]     LAT_CNT     = 4'(LATENCY);
   localparam logic [PC_ADDR:0] RANGE_BYTES = (PC_ADDR+1)'(4) << DEPTH_LOG2;

   state_e                  state_q;
   logic                    req_ready_q;
   logic                    rsp_valid_q;
   logic [DATA_WIDTH-1:0]   rsp_inst_q;
   logic                    rsp_err_q;
   logic [3:0]              cnt_q;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic                    err_q;

   logic [DATA_WIDTH-1:0]   mem_q [2**DEPTH_LOG2];

   logic [PC_ADDR-1:0]      off;
   logic                    hs;
   logic                    hs_err;
   logic [DEPTH_LOG2-1:0]   hs_idx;
   logic [DEPTH_LOG2-1:0]   rd_idx;
   logic [DATA_WIDTH-1:0]   rd_data;

   // With LATENCY==0 the RESP-entry edge is the handshake edge, so the read
   // index comes straight from the request address while still in IDLE.
   always_comb begin
      off     = req_addr_i - BASE_ADDR;
      hs      = req_valid_i && req_ready_q;
      hs_err  = (req_addr_i[1:0] != 2'b00) || ({1'b0, off} >= RANGE_BYTES);
      hs_idx  = off[DEPTH_LOG2+1:2];
      rd_idx  = (state_q == S_IDLE) ? hs_idx : idx_q;
      rd_data = mem_q[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (ld_we_i) begin
         mem_q[ld_addr_i] <= ld_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_inst_q  <= '0;
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
         idx_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (hs) begin
                  idx_q       <= hs_idx;
                  err_q       <= hs_err;
                  req_ready_q <= 1'b0;
                  if (LAT_CNT == 4'd0) begin
                     state_q     <= S_RESP;
                     cnt_q       <= '0;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= hs_err;
                     rsp_inst_q  <= hs_err ? '0 : rd_data;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= LAT_CNT;
                  end
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= err_q;
                  rsp_inst_q  <= err_q ? '0 : rd_data;
               end
            end
            S_RESP: begin
               if (rsp_ready_i) begin
                  state_q     <= S_IDLE;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b0;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_inst_o  = rsp_inst_q;
   assign rsp_err_o   = rsp_err_q;

endmodule
